sample_pacer: RTL and testbench

Upstream feeder for the 3-tap averaging filter. It accepts signed 8-bit samples over a valid/ready handshake and buffers them in a small FIFO. At a programmable sample rate it presents one sample per `avg_en` strobe on `x_in`, which is the filter's input side. Underruns are flagged, and the filter keeps being strobed at a steady rate regardless.

---
 rtl/avg_pkg.sv | 5 +
 rtl/sample_pacer_if.sv | 9 +
 rtl/sample_fifo.sv | 42 ++++
 rtl/sample_pacer.sv | 65 ++++++
 tb/tb_sample_pacer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/avg_pkg.sv
// avg_pkg: sample type and width shared by the pacer and the averaging filter
package avg_pkg;
   localparam int SAMPLE_W = 8;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_pacer_if.sv
// sample_pacer_if: valid/ready sample stream from the upstream producer
interface sample_pacer_if;
   import avg_pkg::*;
   logic    s_valid;
   logic    s_ready;
   sample_t s_data;
   modport master (output s_valid, output s_data, input s_ready);
   modport slave (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: register-array FIFO with occupancy counter and combinational head
module sample_fifo
   import avg_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  sample_t                      data_i,
   output sample_t                      data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   sample_t         mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]   count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = count_q == LW'(DEPTH);
   assign empty_o = count_q == '0;
   assign level_o = count_q;
   // storage needs no reset; only the pointers and count define validity
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end
   // pointers wrap naturally at DEPTH; occupancy tracked separately
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + LW'(push_i) - LW'(pop_i);
      end
   end
endmodule

// File: rtl/sample_pacer.sv
// sample_pacer: buffers samples and strobes them to the filter at a fixed rate
// SAMPLE_PACER_HOLD_LAST_EN: on underrun repeat the last popped sample instead of 0
module sample_pacer
   import avg_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DIV_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   sample_pacer_if.slave                s_if,
   input  logic                         run_i,
   input  logic [DIV_W-1:0]             div_i,
   output logic                         avg_en_o,
   output sample_t                      x_in_o,
   output logic                         underrun_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o
);
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             avg_en_q, underrun_q;
   sample_t          x_q, x_d, head, fill;
   logic             tick, push, pop, full, empty;
   sample_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (s_if.s_data),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level_o)
   );
   assign s_if.s_ready = !full;
   assign push         = s_if.s_valid && !full;
   assign tick         = run_i && (cnt_q >= div_i);
   assign pop          = tick && !empty;
`ifdef SAMPLE_PACER_HOLD_LAST_EN
   assign fill = x_q;
`else
   assign fill = '0;
`endif
   assign avg_en_o   = avg_en_q;
   assign underrun_o = underrun_q;
   assign x_in_o     = x_q;
   // counter restarts on tick or when stopped; x holds between strobes
   always_comb begin
      cnt_d = (!run_i || tick) ? '0 : cnt_q + DIV_W'(1);
      x_d   = tick ? (empty ? fill : head) : x_q;
   end
   // registered strobe outputs; reset also suppresses a pending strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         avg_en_q   <= 1'b0;
         underrun_q <= 1'b0;
         x_q        <= '0;
      end else begin
         cnt_q      <= cnt_d;
         avg_en_q   <= tick;
         underrun_q <= tick && empty;
         x_q        <= x_d;
      end
   end
endmodule

// File: tb/tb_sample_pacer.sv
// tb_sample_pacer: directed and random stimulus against a queue-based reference model
module tb_sample_pacer;
   import avg_pkg::*;
   localparam int DEPTH = 8;
   localparam int DIV_W = 16;
`ifdef SAMPLE_PACER_HOLD_LAST_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst, run, avg_en, underrun;
   logic [DIV_W-1:0] div;
   sample_t x_in;
   logic [$clog2(DEPTH+1)-1:0] level;
   sample_pacer_if bus ();
   sample_pacer #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_if       (bus.slave),
      .run_i      (run),
      .div_i      (div),
      .avg_en_o   (avg_en),
      .x_in_o     (x_in),
      .underrun_o (underrun),
      .level_o    (level)
   );
   always #5 clk = ~clk;
   int checks = 0, failures = 0, cyc = 0, base = 0;
   sample_t q[$];
   int m_cnt = 0;
   logic m_avg = 1'b0, m_under = 1'b0;
   sample_t m_x = '0, m_last = '0;
   sample_t sx[$];
   logic su[$];
   int sc[$];

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear();
      sx.delete();
      su.delete();
      sc.delete();
      base = cyc;
   endtask

   // drive one cycle of inputs, advance the model, then compare after the edge
   task automatic step(input logic r, input logic v, input sample_t d, input logic ru, input logic [DIV_W-1:0] dv);
      logic tk, rdy;
      rst = r;
      bus.s_valid = v;
      bus.s_data = d;
      run = ru;
      div = dv;
      if (r) begin
         q.delete();
         m_cnt = 0;
         m_avg = 1'b0;
         m_under = 1'b0;
         m_x = '0;
         m_last = '0;
      end else begin
         rdy = q.size() < DEPTH;
         tk = ru && (m_cnt >= int'(dv));
         m_cnt = (ru && !tk) ? m_cnt + 1 : 0;
         m_avg = tk;
         m_under = tk && (q.size() == 0);
         if (tk) begin
            if (q.size() > 0) begin
               m_x = q.pop_front();
               m_last = m_x;
            end else begin
               m_x = HOLD ? m_last : sample_t'(0);
            end
         end
         if (v && rdy) q.push_back(d);
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("avg_en", avg_en, m_avg);
      chk("underrun", underrun, m_under);
      chk("x_in", x_in, m_x);
      chk("level", level, q.size());
      chk("s_ready", bus.s_ready, q.size() < DEPTH);
      if (avg_en) begin
         sx.push_back(x_in);
         su.push_back(underrun);
         sc.push_back(cyc - base);
      end
   endtask

   initial begin
      logic v, ru;
      logic [DIV_W-1:0] dv;
      // reset
      step(1, 0, 0, 0, 3);
      step(1, 0, 0, 0, 3);
      chk("rst_ready", bus.s_ready, 1);
      chk("rst_xin", x_in, 0);
      // pacing: three samples at div=3
      step(0, 1, sample_t'(3), 0, 3);
      step(0, 1, sample_t'(-5), 0, 3);
      step(0, 1, sample_t'(127), 0, 3);
      chk("pace_level", level, 3);
      clear();
      for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 3);
      chk("pace_n", sx.size(), 4);
      chk("pace_x0", sx[0], 3);
      chk("pace_x1", sx[1], -5);
      chk("pace_x2", sx[2], 127);
      chk("pace_c0", sc[0], 4);
      chk("pace_c3", sc[3], 16);
      chk("pace_u2", su[2], 0);
      chk("under_u3", su[3], 1);
      chk("under_x3", sx[3], HOLD ? 127 : 0);
      // full FIFO with run stopped
      for (int i = 0; i < 9; i++) step(0, 1, sample_t'(i + 1), 0, 0);
      chk("full_level", level, 8);
      chk("full_ready", bus.s_ready, 0);
      clear();
      step(0, 1, sample_t'(9), 1, 0);
      chk("full_pop_level", level, 7);
      chk("full_pop_ready", bus.s_ready, 1);
      step(0, 1, sample_t'(9), 1, 0);
      chk("full_pushpop_level", level, 7);
      for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0);
      chk("drain_n", sx.size(), 11);
      for (int i = 0; i < 9; i++) chk("drain_x", sx[i], i + 1);
      chk("drain_under", su[9], 1);
      // empty FIFO with push in the tick cycle
      step(0, 1, sample_t'(-128), 1, 0);
      chk("empty_push_under", underrun, 1);
      chk("empty_push_level", level, 1);
      step(0, 0, 0, 1, 0);
      chk("empty_push_x", x_in, -128);
      chk("empty_push_nounder", underrun, 0);
      // divider lowered below the running count
      step(0, 0, 0, 0, 10);
      clear();
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 10);
      chk("div_quiet", sx.size(), 0);
      clear();
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 2);
      chk("div_n", sx.size(), 3);
      chk("div_c0", sc[0], 1);
      chk("div_c1", sc[1], 4);
      chk("div_c2", sc[2], 7);
      // reset mid-stream with a strobe due in the reset cycle
      step(0, 0, 0, 0, 3);
      for (int i = 0; i < 5; i++) step(0, 1, sample_t'(10 + i), 0, 3);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 3);
      chk("mid_level", level, 5);
      step(1, 1, sample_t'(55), 1, 3);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_avg", avg_en, 0);
      chk("mid_rst_x", x_in, 0);
      clear();
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 3);
      chk("mid_n", sx.size(), 1);
      chk("mid_c0", sc[0], 4);
      // random traffic
      ru = 1'b1;
      dv = 16'd2;
      for (int i = 0; i < 600; i++) begin
         if ($urandom % 20 == 0) dv = DIV_W'($urandom_range(0, 5));
         if ($urandom % 16 == 0) ru = !ru;
         v = ($urandom % 8) < ((i / 50) % 8);
         step($urandom % 64 == 0, v, sample_t'($urandom), ru, dv);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
